// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the CPU-to-RAM/peripheral bus bridge.
package mio_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM,
        RAM_RD,
        PER,
        DONE
    } bus_state_t;

    localparam logic [3:0]  RAM_REGION = 4'h0;
    localparam logic [3:0]  PER_REGION = 4'hF;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decode: RAM window, peripheral port window, or unmapped.
module mio_addr_decode
    import mio_bus_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PW      = port_w(N_PORTS)
) (
    input  logic [31:0]   addr,
    output logic          is_ram,
    output logic          is_per,
    output logic [PW-1:0] port_idx,
    output logic          unmapped
);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[27:6], addr[1:0]};

    // The full 4-bit index field is range-checked so that aliases above N_PORTS fault.
    assign is_ram   = (addr[31:28] == RAM_REGION);
    assign is_per   = (addr[31:28] == PER_REGION) && (int'(addr[5:2]) < N_PORTS);
    assign port_idx = addr[PW+1:2];
    assign unmapped = !is_ram && !is_per;

endmodule

// File: rtl/mio_bus_pipe.sv
// CPU bus bridge: single outstanding access to a sync-read RAM or an acked peripheral port.
//   state  | meaning
//   IDLE   | waiting for cpu_req; request fields latched on acceptance
//   RAM    | one-cycle RAM address/write strobe
//   RAM_RD | RAM read data returning; captured on exit for reads
//   PER    | peripheral selected, waiting for ack or timeout
//   DONE   | one-cycle cpu_ready pulse with cpu_err
module mio_bus_pipe
    import mio_bus_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int RAM_AW    = 10,
    parameter int TO_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   mem_w,
    input  logic [31:0]            addr_bus,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic [31:0]            ram_wdata,
    output logic                   ram_we,
    input  logic [31:0]            ram_rdata,
    output logic [N_PORTS-1:0]     per_sel,
    output logic                   per_we,
    output logic [31:0]            per_wdata,
    input  logic [32*N_PORTS-1:0]  per_rdata,
    input  logic [N_PORTS-1:0]     per_ack
);

    localparam int PW = port_w(N_PORTS);

    bus_state_t    state;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [PW-1:0] port_q;
    logic [7:0]    to_cnt;

    logic          dec_ram;
    logic          dec_per;
    logic          dec_unmapped;
    logic [PW-1:0] dec_port;
    logic [31:0]   per_slice;
    logic          ack_hit;

    // Decoding the live bus in IDLE sees exactly the value latched at that edge.
    mio_addr_decode #(.N_PORTS(N_PORTS)) u_decode (
        .addr     (addr_bus),
        .is_ram   (dec_ram),
        .is_per   (dec_per),
        .port_idx (dec_port),
        .unmapped (dec_unmapped)
    );

    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = wdata_q;
    assign per_wdata = wdata_q;

    logic unused_addr_q;
    assign unused_addr_q = ^{addr_q[31:RAM_AW+2], addr_q[1:0]};

    always_comb begin
        per_slice = per_rdata[32*port_q +: 32];
        ack_hit   = per_ack[port_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            port_q    <= '0;
            to_cnt    <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            ram_we    <= 1'b0;
            per_we    <= 1'b0;
            per_sel   <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= addr_bus;
                        wdata_q <= cpu_wdata;
                        we_q    <= mem_w;
                        port_q  <= dec_port;
                        if (dec_unmapped) begin
                            state     <= DONE;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            if (!mem_w) cpu_rdata <= ERR_DATA;
                        end else if (dec_ram) begin
                            state  <= RAM;
                            ram_we <= mem_w;
                        end else begin
                            state   <= PER;
                            per_sel <= N_PORTS'(1) << dec_port;
                            per_we  <= mem_w;
                            to_cnt  <= '0;
                        end
                    end
                end
                RAM: state <= RAM_RD;
                RAM_RD: begin
                    if (!we_q) cpu_rdata <= ram_rdata;
                    state     <= DONE;
                    cpu_ready <= 1'b1;
                end
                PER: begin
                    // Ack is checked first so it beats a coincident timeout.
                    if (ack_hit) begin
                        if (!we_q) cpu_rdata <= per_slice;
                        state     <= DONE;
                        cpu_ready <= 1'b1;
                        per_sel   <= '0;
                        per_we    <= 1'b0;
                    end else if (to_cnt == 8'(TO_CYCLES - 1)) begin
                        cpu_rdata <= ERR_DATA;
                        state     <= DONE;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        per_sel   <= '0;
                        per_we    <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_pipe.sv
// Directed bench: transaction-level expectation timeline checked every cycle, plus literal pins.
module tb_mio_bus_pipe;

    localparam int N_PORTS   = 4;
    localparam int RAM_AW    = 10;
    localparam int TO_CYCLES = 15;
    localparam int DEPTH     = 1024;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cpu_req;
    logic                  mem_w;
    logic [31:0]           addr_bus;
    logic [31:0]           cpu_wdata;
    logic [31:0]           cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_err;
    logic [RAM_AW-1:0]     ram_addr;
    logic [31:0]           ram_wdata;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic [N_PORTS-1:0]    per_sel;
    logic                  per_we;
    logic [31:0]           per_wdata;
    logic [32*N_PORTS-1:0] per_rdata;
    logic [N_PORTS-1:0]    per_ack;

    mio_bus_pipe #(.N_PORTS(N_PORTS), .RAM_AW(RAM_AW), .TO_CYCLES(TO_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .mem_w     (mem_w),
        .addr_bus  (addr_bus),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .per_sel   (per_sel),
        .per_we    (per_we),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata),
        .per_ack   (per_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM stub
    logic [31:0] tb_mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we) tb_mem[ram_addr] <= ram_wdata;
        ram_rdata <= tb_mem[ram_addr];
    end

    // Expected per-cycle timeline, indexed by cyc as seen at the falling edge
    bit          e_ready  [DEPTH];
    bit          e_err    [DEPTH];
    bit          e_ramwe  [DEPTH];
    bit [3:0]    e_persel [DEPTH];
    bit          e_perwe  [DEPTH];
    bit          e_ram_chk[DEPTH];
    bit          e_per_chk[DEPTH];
    bit [31:0]   e_ramaddr[DEPTH];
    bit [31:0]   e_wd     [DEPTH];
    bit          e_rd_upd [DEPTH];
    bit [31:0]   e_rd_val [DEPTH];
    logic [31:0] model_mem[0:(1<<RAM_AW)-1];
    logic [31:0] m_rdata = '0;

    int          cnt_we = 0, cnt_sel = 0, cnt_rdy = 0;
    int          rdy_cyc = 0;
    logic        rdy_err;
    logic [31:0] rdy_data;
    logic [3:0]  last_sel;
    int          acc_start, base_we, base_sel, base_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < DEPTH) begin
            if (e_rd_upd[cyc]) m_rdata = e_rd_val[cyc];
            chk("cpu_ready", 32'(cpu_ready), 32'(e_ready[cyc]));
            if (e_ready[cyc]) chk("cpu_err", 32'(cpu_err), 32'(e_err[cyc]));
            chk("ram_we",    32'(ram_we),    32'(e_ramwe[cyc]));
            chk("per_sel",   32'(per_sel),   32'(e_persel[cyc]));
            chk("per_we",    32'(per_we),    32'(e_perwe[cyc]));
            chk("cpu_rdata", cpu_rdata, m_rdata);
            if (e_ram_chk[cyc]) begin
                chk("ram_addr",  32'(ram_addr), e_ramaddr[cyc]);
                chk("ram_wdata", ram_wdata, e_wd[cyc]);
            end
            if (e_per_chk[cyc]) chk("per_wdata", per_wdata, e_wd[cyc]);
        end
        if (ram_we) cnt_we++;
        if (|per_sel) begin
            cnt_sel++;
            last_sel = per_sel;
        end
        if (cpu_ready) begin
            cnt_rdy++;
            rdy_cyc  = cyc;
            rdy_err  = cpu_err;
            rdy_data = cpu_rdata;
        end
    end

    // One CPU access: build the expected timeline from the access rules, then drive it.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_k, input int ack_port, input logic [31:0] ack_d,
                          input int rst_k, input bit hold_req);
        int a0, done, p_len, idx;
        bit hit;
        @(negedge clk);
        a0 = cyc + 1;
        cpu_req = 1'b1; mem_w = we; addr_bus = a; cpu_wdata = wd;
        idx = int'(a[5:2]);
        base_we = cnt_we; base_sel = cnt_sel; base_rdy = cnt_rdy; acc_start = a0;
        if (a[31:28] == 4'h0) begin
            e_ramwe[a0] = we; e_ram_chk[a0] = 1'b1;
            e_ramaddr[a0] = 32'(a[RAM_AW+1:2]); e_wd[a0] = wd;
            done = a0 + 2;
            e_ready[done] = 1'b1;
            if (!we) begin
                e_rd_upd[done] = 1'b1;
                e_rd_val[done] = model_mem[a[RAM_AW+1:2]];
            end else begin
                model_mem[a[RAM_AW+1:2]] = wd;
            end
        end else if (a[31:28] == 4'hF && idx < N_PORTS) begin
            hit   = (ack_k >= 1) && (ack_k <= TO_CYCLES) && (ack_port == idx);
            p_len = hit ? ack_k : TO_CYCLES;
            if (rst_k > 0) p_len = rst_k;
            for (int n = 0; n < p_len; n++) begin
                e_persel[a0+n] = 4'(1 << idx);
                e_perwe[a0+n]  = we;
            end
            e_per_chk[a0] = 1'b1; e_wd[a0] = wd;
            done = a0 + p_len;
            if (rst_k > 0) begin
                e_rd_upd[done] = 1'b1; e_rd_val[done] = '0;
            end else begin
                e_ready[done] = 1'b1;
                e_err[done]   = !hit;
                if (!hit) begin
                    e_rd_upd[done] = 1'b1; e_rd_val[done] = 32'hDEAD_BEEF;
                end else if (!we) begin
                    e_rd_upd[done] = 1'b1; e_rd_val[done] = ack_d;
                end
            end
        end else begin
            done = a0;
            e_ready[done] = 1'b1;
            e_err[done]   = 1'b1;
            if (!we) begin
                e_rd_upd[done] = 1'b1; e_rd_val[done] = 32'hDEAD_BEEF;
            end
        end
        for (int n = 1; n <= done - a0 + 2; n++) begin
            @(negedge clk);
            if (!hold_req) cpu_req = 1'b0;
            per_ack = '0;
            if (n == ack_k) begin
                per_ack[ack_port] = 1'b1;
                per_rdata[32*ack_port +: 32] = ack_d;
            end
            if (rst_k > 0 && n == rst_k) begin
                rst = 1'b1; cpu_req = 1'b0;
            end else begin
                rst = 1'b0;
            end
        end
        cpu_req = 1'b0;
        per_ack = '0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1<<RAM_AW); i++) begin
            tb_mem[i] = '0;
            model_mem[i] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) per_rdata[32*p +: 32] = {16'hBAD0, 16'(p)};
        rst = 1'b1; cpu_req = 1'b0; mem_w = 1'b0; addr_bus = '0; cpu_wdata = '0; per_ack = '0;
        repeat (3) @(negedge clk);
        chk("rst_ram_addr",  32'(ram_addr), 32'h0);
        chk("rst_per_wdata", per_wdata, 32'h0);
        chk("rst_rdata",     cpu_rdata, 32'h0);
        rst = 1'b0;

        // RAM write then read-back
        access(1'b1, 32'h0000_0010, 32'h1234_5678, 0, 0, '0, 0, 1'b0);
        chk("wr_we_pulses",  32'(cnt_we - base_we), 32'd1);
        chk("wr_ready_cyc",  32'(rdy_cyc - acc_start + 1), 32'd3);
        chk("wr_err",        32'(rdy_err), 32'd0);
        access(1'b0, 32'h0000_0010, 32'h0, 0, 0, '0, 0, 1'b0);
        chk("rd_data",       rdy_data, 32'h1234_5678);
        chk("rd_ready_cyc",  32'(rdy_cyc - acc_start + 1), 32'd3);
        chk("rd_no_we",      32'(cnt_we - base_we), 32'd0);

        // Top RAM word
        access(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 0, '0, 0, 1'b0);
        access(1'b0, 32'h0000_0FFC, 32'h0, 0, 0, '0, 0, 1'b0);
        chk("top_word_data", rdy_data, 32'hCAFE_F00D);

        // Peripheral read, port 2, ack on third PER cycle
        access(1'b0, 32'hF000_0008, 32'h0, 3, 2, 32'hA5A5_0002, 0, 1'b0);
        chk("per_sel_cycles", 32'(cnt_sel - base_sel), 32'd3);
        chk("per_sel_value",  32'(last_sel), 32'h4);
        chk("per_rd_data",    rdy_data, 32'hA5A5_0002);
        chk("per_rd_pulses",  32'(cnt_rdy - base_rdy), 32'd1);

        // Peripheral write, port 0, immediate ack: read data untouched
        access(1'b1, 32'hF000_0000, 32'h0000_55AA, 1, 0, 32'h1111_0000, 0, 1'b0);
        chk("per_wr_keep", rdy_data, 32'hA5A5_0002);
        chk("per_wr_err",  32'(rdy_err), 32'd0);

        // Timeout on port 1
        access(1'b0, 32'hF000_0004, 32'h0, 0, 1, '0, 0, 1'b0);
        chk("to_sel_cycles", 32'(cnt_sel - base_sel), 32'd15);
        chk("to_err",        32'(rdy_err), 32'd1);
        chk("to_data",       rdy_data, 32'hDEAD_BEEF);
        chk("to_ready_cyc",  32'(rdy_cyc - acc_start + 1), 32'd16);

        // Ack coincides with the last allowed cycle: ack wins
        access(1'b0, 32'hF000_000C, 32'h0, 15, 3, 32'h3333_0003, 0, 1'b0);
        chk("ackwin_err",  32'(rdy_err), 32'd0);
        chk("ackwin_data", rdy_data, 32'h3333_0003);

        // Unmapped accesses
        access(1'b0, 32'h8000_0000, 32'h0, 0, 0, '0, 0, 1'b0);
        chk("unm1_ready_cyc", 32'(rdy_cyc - acc_start + 1), 32'd1);
        chk("unm1_err",       32'(rdy_err), 32'd1);
        chk("unm1_data",      rdy_data, 32'hDEAD_BEEF);
        access(1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 0, 0, '0, 0, 1'b0);
        access(1'b0, 32'hF000_0010, 32'h0, 1, 0, 32'h7777_0000, 0, 1'b0);
        chk("unm2_ready_cyc", 32'(rdy_cyc - acc_start + 1), 32'd1);
        chk("unm2_err",       32'(rdy_err), 32'd1);
        chk("unm2_data",      rdy_data, 32'hDEAD_BEEF);
        chk("unm2_no_sel",    32'(cnt_sel - base_sel), 32'd0);
        chk("unm2_no_we",     32'(cnt_we - base_we), 32'd0);
        access(1'b0, 32'h0000_0010, 32'h0, 0, 0, '0, 0, 1'b0);
        access(1'b1, 32'h1000_0000, 32'h0, 0, 0, '0, 0, 1'b0);
        chk("unm3_err",  32'(rdy_err), 32'd1);
        chk("unm3_keep", rdy_data, 32'h0BAD_CAFE);

        // Reset in second PER cycle with a wrong-port ack and cpu_req held busy
        access(1'b0, 32'hF000_0008, 32'h0, 1, 0, 32'h9999_0000, 2, 1'b1);
        chk("rst_no_ready",  32'(cnt_rdy - base_rdy), 32'd0);
        chk("rst_sel_cycles", 32'(cnt_sel - base_sel), 32'd2);
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_accept", 32'(cnt_sel - base_sel), 32'd2);
        chk("rst_rdata_clr", cpu_rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mio_bus_pipe.md
MIO_BUS_PIPE -- requirements
Module: mio_bus_pipe

Interface
REQ-001 Parameter N_PORTS, default 4: number of peripheral ports, range 1..16; PW = max(1, clog2(N_PORTS)).
REQ-002 Parameter RAM_AW, default 10: RAM word-address width.
REQ-003 Parameter TO_CYCLES, default 15: maximum cycles spent waiting for a peripheral ack, range 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cpu_req  in  1  CPU access request, sampled only in IDLE.
REQ-007 mem_w  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-008 addr_bus  in  32  CPU byte address.
REQ-009 cpu_wdata  in  32  CPU write data.
REQ-010 cpu_rdata  out  32  registered read data to CPU.
REQ-011 cpu_ready  out  1  one-cycle completion pulse.
REQ-012 cpu_err  out  1  error flag, valid while cpu_ready = 1.
REQ-013 ram_addr  out  RAM_AW  RAM word address.
REQ-014 ram_wdata  out  32  RAM write data.
REQ-015 ram_we  out  1  RAM write strobe.
REQ-016 ram_rdata  in  32  synchronous-read RAM data, valid one cycle after address.
REQ-017 per_sel  out  N_PORTS  one-hot peripheral select.
REQ-018 per_we  out  1  peripheral write enable.
REQ-019 per_wdata  out  32  peripheral write data.
REQ-020 per_rdata  in  32*N_PORTS  peripheral read data; port i at bits [32i+31:32i].
REQ-021 per_ack  in  N_PORTS  per-port completion ack.

Function
REQ-022 Decode SHALL use the latched address:
- addr[31:28] = 4'h0: RAM, word address addr[RAM_AW+1:2].
- addr[31:28] = 4'hF: peripheral port addr[PW+1:2]; an index >= N_PORTS is unmapped.
- Any other value: unmapped.
REQ-023 FSM states SHALL be IDLE, RAM, RAM_RD, PER, DONE.
REQ-024 In IDLE with cpu_req = 1, the block SHALL latch addr_bus, cpu_wdata and mem_w, then go to RAM or PER; unmapped addresses go straight to DONE with error.
REQ-025 ram_addr, ram_wdata and per_wdata SHALL be driven from the latched registers.
REQ-026 RAM state, one cycle: ram_we = latched mem_w; next state RAM_RD.
REQ-027 RAM_RD state: cpu_rdata SHALL load ram_rdata on exit for reads and stay unchanged for writes; next state DONE.
REQ-028 RAM access timing: request accepted at edge 0 gives cpu_ready high in cycle 3.
REQ-029 PER state: per_sel SHALL be one-hot for the decoded port, and per_we = latched mem_w; both held until exit.
REQ-030 In PER, per_ack of the selected port SHALL cause cpu_rdata to load that port's slice (reads only) and the FSM to go to DONE with no error; acks from other ports are ignored.
REQ-031 Timeout counter:
- cleared on entry to PER, incremented each PER cycle without ack;
- at count TO_CYCLES-1 with no ack, go to DONE with error and load cpu_rdata with 32'hDEAD_BEEF.
REQ-032 Ack and timeout in the same cycle: ack SHALL win.
REQ-033 DONE state: cpu_ready = 1 for exactly one cycle; cpu_err = 1 on unmapped access or timeout; next state IDLE.
REQ-034 cpu_req SHALL be ignored outside IDLE; back-to-back requests are accepted no earlier than the cycle after DONE.
REQ-035 For unmapped reads, cpu_rdata SHALL be 32'hDEAD_BEEF.
REQ-036 ram_we, per_sel and per_we SHALL be 0 in all states other than those stated above.

Reset
REQ-037 On rst = 1 at a clock edge: state = IDLE; cpu_rdata, latched registers and the timeout counter = 0; cpu_ready, cpu_err, ram_we, per_we and per_sel = 0.
REQ-038 Reset mid-access SHALL abort with no completion pulse; strobes and selects drop at that same edge.

Structure
REQ-039 Package mio_bus_pkg SHALL hold the state enum, region constants RAM_REGION = 4'h0 and PER_REGION = 4'hF, and ERR_DATA = 32'hDEAD_BEEF.
REQ-040 One combinational sub-module, mio_addr_decode, SHALL map an address to {is_ram, is_per, port_idx, unmapped}.

Verification
REQ-041 RAM write then read: write 0x0000_0010 data 0x1234_5678 -> ram_we pulses once with ram_addr = 4 and ready in cycle 3; read with ram_rdata = 0x1234_5678 -> cpu_rdata = 0x1234_5678, cpu_err = 0.
REQ-042 Peripheral read: 0xF000_0008 (port 2), ack on third PER cycle with data 0xA5A5_0002 -> per_sel = 4'b0100 held for 3 cycles, cpu_rdata = 0xA5A5_0002, single ready pulse.
REQ-043 Timeout: port 1 never acks, TO_CYCLES = 15 -> per_sel held for exactly 15 cycles, then ready with cpu_err = 1 and cpu_rdata = 0xDEAD_BEEF.
REQ-044 Unmapped 0x8000_0000 and 0xF000_0010 (N_PORTS = 4) -> ready in cycle 1 with cpu_err = 1; no ram_we and no per_sel.
REQ-045 rst asserted in the second PER cycle, with a wrong-port ack and cpu_req held high during busy -> outputs clear at the reset edge, no ready pulse, the wrong-port ack is ignored, and no extra access is accepted.
